chunked_adder: RTL and testbench
================================

# chunked_adder

Parametrised multi-cycle adder/subtractor for the 24-bit CPU datapath. It adds or subtracts two WIDTH-bit operands CHUNK bits per clock, rippling the carry between chunks through a registered carry flop, so the width scales without a long combinational carry chain. A start/busy/done handshake connects it to a controller. It reports carry-out, signed overflow and zero flags.

## Interface
- WIDTH, 24: operand and result width in bits; must be a multiple of CHUNK.
- CHUNK, 4: bits processed per cycle. N = WIDTH/CHUNK chunk cycles; CHUNK = WIDTH gives N = 1.
- clk  in  1  sole clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  request; sampled only when the block is not busy.
- sub  in  1  0: a+b+cin; 1: a-b-cin (cin acts as borrow-in).
- a, b  in  WIDTH  operands, captured on the accepting edge.
- cin  in  1  carry-in (borrow-in when sub=1), captured with the operands.
- busy  out  1  high while chunks are being processed.
- done  out  1  one-cycle pulse: results valid.
- sum  out  WIDTH  result of the last completed operation.
- cout  out  1  carry out of the MSB; for sub=1, 1 means no borrow.
- overflow  out  1  signed two's-complement overflow.
- zero  out  1  sum == 0.

## Operation
- States: IDLE, RUN, DONE.
- IDLE or DONE with start=1 at an edge (the accepting edge):
  - latch a into opa;
  - latch opb = sub ? ~b : b;
  - latch carry = sub ? ~cin : cin;
  - clear the partial register and set idx=0;
  - go to RUN.
- IDLE with start=0: stay in IDLE. DONE with start=0: go to IDLE after one cycle.
- RUN, each edge:
  - compute opa[idx*CHUNK +: CHUNK] + opb[idx*CHUNK +: CHUNK] + carry;
  - write the low CHUNK bits into partial;
  - store the chunk carry-out in carry;
  - increment idx.
- On the edge that processes chunk N-1:
  - sum <= full result;
  - cout <= final carry;
  - overflow <= carry into MSB XOR carry out of MSB;
  - zero <= (full result == 0);
  - go to DONE.
- start while in RUN is ignored; operands are not re-captured.
- sum, cout, overflow and zero change only on completion. They hold until the next completion or reset.
- Elaboration fails ($error) if WIDTH % CHUNK != 0 or CHUNK < 1.

## Timing
- Reset (asynchronous, immediate):
  - state IDLE, idx=0;
  - busy=0, done=0, sum=0, cout=0, overflow=0, zero=0.
- busy = (state == RUN); it rises the cycle after the accepting edge.
- done = (state == DONE); it is high for exactly one cycle.
- Latency: N edges after the accepting edge, done=1 and the results are valid together. busy falls on that same edge.
- Default 24/4: N=6 chunk edges; throughput one operation per N+1 cycles.
- Back-to-back: start=1 during the DONE cycle is accepted, and busy rises on the next cycle. The old results remain visible until the new operation completes.
- Reset mid-RUN aborts the operation: no done pulse, the results are cleared to 0, and the partial result is discarded.
- Reset deasserting while start=1: start is accepted on the first edge with rst_n=1.
- CHUNK=WIDTH: the RUN state lasts one edge, so done rises one edge after acceptance.

## Test plan
- Add, default parameters: a=0x123456, b=0x654321, cin=0, sub=0 -> after 6 edges, done=1 for one cycle, sum=0x777777, cout=0, overflow=0, zero=0; busy was high for 6 cycles.
- Wrap to zero: a=0xFFFFFF, b=0x000001, cin=0 -> sum=0x000000, cout=1, zero=1, overflow=0.
- Subtract with borrow: a=0x000005, b=0x000007, cin=0, sub=1 -> sum=0xFFFFFE, cout=0, overflow=0. Then a=0x000009, b=0x000007, cin=1, sub=1 -> sum=0x000001, cout=1.
- Signed overflow: a=0x7FFFFF, b=0x000001, sub=0 -> sum=0x800000, overflow=1, cout=0.
- Handshake: start with a=1, b=1; at edge 2 of RUN, assert start with a=0x10 -> ignored, result sum=0x000002. Assert start with a=3, b=4 during the DONE cycle -> accepted; the next done gives sum=0x000007.
- Reset and parameter variant: assert rst_n=0 at RUN edge 3 -> all outputs 0 immediately and no done; a new operation then completes normally. With WIDTH=8, CHUNK=8: a=0xF0, b=0x20 -> done one edge after acceptance, sum=0x10, cout=1.

Source files
------------

// File: rtl/chunked_adder.sv
// Multi-cycle adder/subtractor: CHUNK bits per clock, carry rippled through a flop.
// Latency WIDTH/CHUNK edges after acceptance; start is ignored while busy (no queueing).
module chunked_adder #(
    parameter int WIDTH = 24,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             overflow,
    output logic             zero
);

    localparam int N    = (CHUNK < 1) ? 1 : WIDTH / CHUNK;
    localparam int IDXW = (N > 1) ? $clog2(N) : 1;
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(N - 1);
    localparam bit  BAD_PARAMS = (CHUNK < 1) ? 1'b1 : ((WIDTH % CHUNK) != 0);

    generate
        if (BAD_PARAMS) begin : g_param_err
            $error("chunked_adder: WIDTH must be a positive multiple of CHUNK");
        end
    endgenerate

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] opa_q, opa_d;
    logic [WIDTH-1:0] opb_q, opb_d;
    logic [WIDTH-1:0] partial_q, partial_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic [IDXW-1:0]  idx_q, idx_d;
    logic             carry_q, carry_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;
    logic             zero_q, zero_d;

    logic [CHUNK:0]   chunk_res;
    logic [WIDTH-1:0] result;
    logic             msb_cin;

    // Operands shift right each cycle, so the active chunk always sits in the low bits;
    // the partial result fills from the top and is complete after the last chunk.
    always_comb begin
        chunk_res = {1'b0, opa_q[CHUNK-1:0]} + {1'b0, opb_q[CHUNK-1:0]}
                  + {{CHUNK{1'b0}}, carry_q};
        result    = (partial_q >> CHUNK)
                  | (WIDTH'(chunk_res[CHUNK-1:0]) << (WIDTH - CHUNK));
        msb_cin   = opa_q[CHUNK-1] ^ opb_q[CHUNK-1] ^ chunk_res[CHUNK-1];
    end

    always_comb begin
        state_d   = state_q;
        opa_d     = opa_q;
        opb_d     = opb_q;
        partial_d = partial_q;
        idx_d     = idx_q;
        carry_d   = carry_q;
        sum_d     = sum_q;
        cout_d    = cout_q;
        ovf_d     = ovf_q;
        zero_d    = zero_q;

        if (state_q == RUN) begin
            opa_d     = opa_q >> CHUNK;
            opb_d     = opb_q >> CHUNK;
            carry_d   = chunk_res[CHUNK];
            partial_d = result;
            idx_d     = idx_q + 1'b1;
            if (idx_q == LAST_IDX) begin
                sum_d   = result;
                cout_d  = chunk_res[CHUNK];
                ovf_d   = msb_cin ^ chunk_res[CHUNK];
                zero_d  = (result == '0);
                state_d = DONE;
            end
        end else if (start) begin
            // Subtraction runs as a + ~b + ~cin, so cin doubles as borrow-in.
            opa_d     = a;
            opb_d     = sub ? ~b : b;
            carry_d   = cin ^ sub;
            partial_d = '0;
            idx_d     = '0;
            state_d   = RUN;
        end else begin
            state_d   = IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            opa_q     <= '0;
            opb_q     <= '0;
            partial_q <= '0;
            idx_q     <= '0;
            carry_q   <= 1'b0;
            sum_q     <= '0;
            cout_q    <= 1'b0;
            ovf_q     <= 1'b0;
            zero_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            opa_q     <= opa_d;
            opb_q     <= opb_d;
            partial_q <= partial_d;
            idx_q     <= idx_d;
            carry_q   <= carry_d;
            sum_q     <= sum_d;
            cout_q    <= cout_d;
            ovf_q     <= ovf_d;
            zero_q    <= zero_d;
        end
    end

    assign busy     = (state_q == RUN);
    assign done     = (state_q == DONE);
    assign sum      = sum_q;
    assign cout     = cout_q;
    assign overflow = ovf_q;
    assign zero     = zero_q;

endmodule

// File: tb/tb_chunked_adder.sv
// Scoreboard bench for chunked_adder: default 24/4 instance plus an 8/8 single-chunk instance.
module tb_chunked_adder;

    localparam int W  = 24;
    localparam int NC = 6;

    typedef struct packed {
        logic [W-1:0] sum;
        logic         cout;
        logic         ovf;
        logic         zero;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start, sub, cin;
    logic [W-1:0] a, b;
    logic         busy, done, cout, overflow, zero;
    logic [W-1:0] sum;

    logic         start8, sub8, cin8;
    logic [7:0]   a8, b8, sum8;
    logic         busy8, done8, cout8, ovf8, zero8;

    exp_t         exp_q[$];
    exp_t         mon_e;
    logic [W-1:0] last_sum;
    int           n_chk = 0;
    int           n_err = 0;

    always #5 clk = ~clk;

    chunked_adder #(.WIDTH(24), .CHUNK(4)) u_dut (
        .clk(clk), .rst_n(rst_n), .start(start), .sub(sub), .a(a), .b(b), .cin(cin),
        .busy(busy), .done(done), .sum(sum), .cout(cout), .overflow(overflow), .zero(zero)
    );

    chunked_adder #(.WIDTH(8), .CHUNK(8)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .sub(sub8), .a(a8), .b(b8), .cin(cin8),
        .busy(busy8), .done(done8), .sum(sum8), .cout(cout8), .overflow(ovf8), .zero(zero8)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_chk++;
        if (obs !== expv) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, expv);
        end
    endtask

    // Reference built from integer arithmetic: borrow and signed range checked directly.
    function automatic exp_t model(input logic [W-1:0] ta, input logic [W-1:0] tb_,
                                   input logic tc, input logic ts);
        logic [W:0] full;
        int         sa, sb, r;
        exp_t       e;
        sa = int'($signed(ta));
        sb = int'($signed(tb_));
        if (ts) begin
            full   = {1'b0, ta} - {1'b0, tb_} - (W+1)'(tc);
            e.cout = ~full[W];
            r      = sa - sb - int'(tc);
        end else begin
            full   = {1'b0, ta} + {1'b0, tb_} + (W+1)'(tc);
            e.cout = full[W];
            r      = sa + sb + int'(tc);
        end
        e.sum  = full[W-1:0];
        e.ovf  = (r > 8388607) || (r < -8388608);
        e.zero = (e.sum == '0);
        return e;
    endfunction

    task automatic push_exp(input logic [W-1:0] ta, input logic [W-1:0] tb_,
                            input logic tc, input logic ts);
        exp_t e;
        e = model(ta, tb_, tc, ts);
        exp_q.push_back(e);
        last_sum = e.sum;
    endtask

    always @(negedge clk) begin
        if (rst_n && done) begin
            if (exp_q.size() == 0) begin
                chk("done_without_op", 32'(done), 32'd0);
            end else begin
                mon_e = exp_q.pop_front();
                chk("sum",      32'(sum),      32'(mon_e.sum));
                chk("cout",     32'(cout),     32'(mon_e.cout));
                chk("overflow", 32'(overflow), 32'(mon_e.ovf));
                chk("zero",     32'(zero),     32'(mon_e.zero));
            end
        end
    end

    task automatic wait_done(output int nbusy, output bit got);
        nbusy = 0;
        got   = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            if (busy) nbusy++;
            if (done) got = 1'b1;
        end
    endtask

    task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_,
                          input logic tc, input logic ts);
        int nbusy;
        bit got;
        a = ta; b = tb_; cin = tc; sub = ts; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        push_exp(ta, tb_, tc, ts);
        wait_done(nbusy, got);
        chk("done_seen", 32'(got), 32'd1);
        chk("busy_cycles", 32'(nbusy), 32'(NC));
        @(negedge clk);
        chk("done_one_cycle", 32'(done), 32'd0);
    endtask

    initial begin
        int nbusy;
        bit got;
        logic [W-1:0] hold_sum;

        rst_n = 1'b0; start = 1'b0; sub = 1'b0; cin = 1'b0; a = '0; b = '0;
        start8 = 1'b0; sub8 = 1'b0; cin8 = 1'b0; a8 = '0; b8 = '0;
        last_sum = '0;
        #1;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_sum",  32'(sum),  32'd0);
        chk("rst_cout", 32'(cout), 32'd0);
        chk("rst_ovf",  32'(overflow), 32'd0);
        chk("rst_zero", 32'(zero), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        run_op(24'h123456, 24'h654321, 1'b0, 1'b0);
        run_op(24'hFFFFFF, 24'h000001, 1'b0, 1'b0);
        run_op(24'h000005, 24'h000007, 1'b0, 1'b1);
        run_op(24'h000009, 24'h000007, 1'b1, 1'b1);
        run_op(24'h7FFFFF, 24'h000001, 1'b0, 1'b0);
        run_op(24'h800000, 24'h000001, 1'b0, 1'b1);

        // Start during RUN must be ignored; results hold until completion.
        hold_sum = last_sum;
        a = 24'h1; b = 24'h1; cin = 1'b0; sub = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        push_exp(24'h1, 24'h1, 1'b0, 1'b0);
        @(posedge clk); #1;
        a = 24'h10; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk("hold_during_run", 32'(sum), 32'(hold_sum));
        chk("busy_after_ignored_start", 32'(busy), 32'd1);
        wait_done(nbusy, got);
        chk("hs_done_seen", 32'(got), 32'd1);
        chk("hs_busy_cycles", 32'(nbusy), 32'(NC - 2));
        hold_sum = last_sum;
        a = 24'h3; b = 24'h4; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        push_exp(24'h3, 24'h4, 1'b0, 1'b0);
        @(negedge clk);
        chk("b2b_busy", 32'(busy), 32'd1);
        chk("b2b_old_visible", 32'(sum), 32'(hold_sum));
        wait_done(nbusy, got);
        chk("b2b_done_seen", 32'(got), 32'd1);
        chk("b2b_busy_cycles", 32'(nbusy), 32'(NC - 1));
        @(negedge clk);

        // Reset at RUN edge 3 aborts without a done pulse.
        a = 24'h111111; b = 24'h000001; cin = 1'b0; sub = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        chk("abort_sum",  32'(sum),  32'd0);
        chk("abort_cout", 32'(cout), 32'd0);
        chk("abort_ovf",  32'(overflow), 32'd0);
        chk("abort_zero", 32'(zero), 32'd0);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk("abort_no_done", 32'(done), 32'd0);
        end
        start = 1'b1;
        rst_n = 1'b1;
        run_op(24'h0ABCDE, 24'h012345, 1'b1, 1'b0);

        for (int i = 0; i < 20; i++) begin
            run_op(W'($urandom), W'($urandom), 1'($urandom), 1'($urandom));
        end
        chk("sb_drained", 32'(exp_q.size()), 32'd0);

        // Single-chunk instance: done one edge after acceptance.
        a8 = 8'hF0; b8 = 8'h20; start8 = 1'b1;
        @(posedge clk); #1;
        start8 = 1'b0;
        chk("w8_busy", 32'(busy8), 32'd1);
        @(posedge clk); #1;
        chk("w8_done", 32'(done8), 32'd1);
        chk("w8_sum",  32'(sum8),  32'h10);
        chk("w8_cout", 32'(cout8), 32'd1);
        chk("w8_ovf",  32'(ovf8),  32'd0);
        chk("w8_zero", 32'(zero8), 32'd0);
        @(posedge clk); #1;
        chk("w8_done_one_cycle", 32'(done8), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "watchdog");
    end

endmodule
